regfile_2w2r_sb: RTL and testbench
==================================

Name: regfile_2w2r_sb

Overview:
Parametrised successor to the MIPS 32x32 register file. It has configurable width and depth and two read ports. It has two write ports: an ALU writeback port (port 3) and a load writeback port (port 4). Optional write-to-read bypass is included, and register 0 can be hardwired to zero. A per-register busy scoreboard lets the pipeline reserve a destination at issue and release it at writeback, so the stall logic can detect RAW hazards. It sits between decode (reads, reserve) and the writeback stages of the pipelined MIPS core.

Parameters:
WIDTH, 32, data width of each register
AW, 5, address width; depth = 2**AW registers
ZERO_REG, 1, 1 = register 0 reads 0, is never written and is never busy
BYPASS, 1, 1 = same-cycle writes are forwarded to the read ports and to the busy flags

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
a1_in  in  AW  read address, port 1
a2_in  in  AW  read address, port 2
rd1  out  WIDTH  read data, port 1
rd2  out  WIDTH  read data, port 2
busy1  out  1  register at a1_in has a pending write
busy2  out  1  register at a2_in has a pending write
a3_in  in  AW  write address, port 3 (ALU writeback)
wd3  in  WIDTH  write data, port 3
we3  in  1  write enable, port 3
a4_in  in  AW  write address, port 4 (load writeback)
wd4  in  WIDTH  write data, port 4
we4  in  1  write enable, port 4
rsv_en  in  1  reserve the destination at rsv_addr (set its busy bit)
rsv_addr  in  AW  destination being reserved
busy_cnt  out  AW+1  number of busy registers

Behaviour:
- Reset (asynchronous, any time, including mid-write):
  - all registers clear to 0 and all busy bits clear to 0;
  - outputs then read rd1/rd2 = 0, busy1/busy2 = 0, busy_cnt = 0;
  - reset overrides any write or reserve in the same cycle.
- Writes:
  - Registers update on the rising edge when the write enable is high.
  - If we3 and we4 target the same address in the same cycle, port 4 data is stored (port 4 has priority).
  - Writes to address 0 are dropped when ZERO_REG = 1.
  - When ZERO_REG = 0, register 0 is an ordinary register.
- Reads are combinational, with zero cycles of latency:
  - ZERO_REG = 1 and address 0 -> 0.
  - Otherwise, with BYPASS = 1, a same-cycle write to the read address is forwarded: wd4 if we4 matches, else wd3 if we3 matches, else the stored value.
  - With BYPASS = 0, the read returns the stored value only; the new value is visible the cycle after the edge.
- Scoreboard, one busy bit per register, updated at the rising edge:
  - A write on either port clears the busy bit at its address.
  - rsv_en sets the busy bit at rsv_addr.
  - Reserve and write to the same address in the same cycle -> bit ends set (reserve wins; a new producer supersedes the old one).
  - Reserving an address that is already busy -> bit stays set.
  - Writing an address that is not busy -> bit stays clear.
  - With ZERO_REG = 1, reserves of address 0 are ignored.
- busy1/busy2 are combinational:
  - they show the busy bit at the read address;
  - with BYPASS = 1, they are forced to 0 when a same-cycle write hits that address;
  - they are forced to 0 for address 0 when ZERO_REG = 1.
  - A same-cycle rsv_en does not raise them; the reservation is visible next cycle.
- busy_cnt is registered: the population count of the busy bits after each edge.
  - Maximum value is 2**AW when ZERO_REG = 0, and 2**AW - 1 when ZERO_REG = 1.
- Address inputs are full width; no out-of-range case exists.

Test Plan:
- Apply and release reset, then read every address on both ports -> all rd = 0, busy1 = busy2 = 0, busy_cnt = 0.
- Write 0xDEADBEEF to address 5 via port 3 while a1_in = 5 -> with BYPASS = 1, rd1 = 0xDEADBEEF in the same cycle; with BYPASS = 0, rd1 = 0 that cycle and 0xDEADBEEF the next.
- Drive we3 (addr 9, 0x11111111) and we4 (addr 9, 0x22222222) in the same cycle -> rd1 at addr 9 reads 0x22222222 afterwards.
- Write 0xFFFFFFFF to address 0 and reserve address 0 (ZERO_REG = 1) -> rd = 0, busy = 0 and busy_cnt unchanged.
- Reserve addr 7 (busy_cnt = 1, busy1 = 1 next cycle), then in one cycle write addr 7 via port 4 and reserve addr 7 -> busy stays 1 and busy_cnt stays 1. Then write addr 7 alone -> busy1 = 0 in that same cycle, and busy_cnt = 0 after the edge.
- Reserve addresses 1..31 on consecutive cycles, then assert reset mid-sequence -> busy_cnt climbs to 31 (AW = 5), then drops immediately to 0 with every register cleared.

Source files
------------

// File: rtl/regfile_2w2r_sb_if.sv
// Decode/writeback bus of the scoreboarded register file: two read ports,
// two writeback ports, a destination-reserve port and the busy count.
interface regfile_2w2r_sb_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic [AW-1:0]    a1_in;
  logic [AW-1:0]    a2_in;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             busy1;
  logic             busy2;
  logic [AW-1:0]    a3_in;
  logic [WIDTH-1:0] wd3;
  logic             we3;
  logic [AW-1:0]    a4_in;
  logic [WIDTH-1:0] wd4;
  logic             we4;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic [AW:0]      busy_cnt;

  // Pipeline side: decode and writeback stages drive addresses and data
  modport master (
    output a1_in, a2_in, a3_in, wd3, we3, a4_in, wd4, we4, rsv_en, rsv_addr,
    input  rd1, rd2, busy1, busy2, busy_cnt
  );

  modport slave (
    input  a1_in, a2_in, a3_in, wd3, we3, a4_in, wd4, we4, rsv_en, rsv_addr,
    output rd1, rd2, busy1, busy2, busy_cnt
  );
endinterface

// File: rtl/regfile_2w2r_sb.sv
// Two-read/two-write register file with a per-register busy scoreboard for
// RAW hazard detection; the load port (4) wins over the ALU port (3).
module regfile_2w2r_sb #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic              clock,
  input logic              reset,
  regfile_2w2r_sb_if.slave bus
);
  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;

  logic             we3_ok;
  logic             we4_ok;
  logic             rsv_ok;

  logic [1:0][AW-1:0]    rd_addr;
  logic [1:0][WIDTH-1:0] rd_data;
  logic [1:0]            rd_busy;
  logic [1:0]            hit3;
  logic [1:0]            hit4;

  // Register 0 swallows writes and reserves when it is hardwired to zero
  assign we3_ok = bus.we3 && !(ZERO_REG != 0 && bus.a3_in == '0);
  assign we4_ok = bus.we4 && !(ZERO_REG != 0 && bus.a4_in == '0);
  assign rsv_ok = bus.rsv_en && !(ZERO_REG != 0 && bus.rsv_addr == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (we3_ok) begin
        regs[bus.a3_in] <= bus.wd3;
      end
      if (we4_ok) begin
        regs[bus.a4_in] <= bus.wd4;
      end
    end
  end

  // Writes retire a producer; a same-cycle reserve names a newer one and wins
  always_comb begin
    busy_d = busy_q;
    if (we3_ok) begin
      busy_d[bus.a3_in] = 1'b0;
    end
    if (we4_ok) begin
      busy_d[bus.a4_in] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[bus.rsv_addr] = 1'b1;
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rd_addr[0] = bus.a1_in;
  assign rd_addr[1] = bus.a2_in;

  assign hit3[0] = we3_ok && (bus.a3_in == rd_addr[0]);
  assign hit3[1] = we3_ok && (bus.a3_in == rd_addr[1]);
  assign hit4[0] = we4_ok && (bus.a4_in == rd_addr[0]);
  assign hit4[1] = we4_ok && (bus.a4_in == rd_addr[1]);

  // A forwarded write also means the pending producer has just delivered
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs[rd_addr[p]];
      rd_busy[p] = busy_q[rd_addr[p]];
      if (BYPASS != 0) begin
        if (hit4[p]) begin
          rd_data[p] = bus.wd4;
        end else if (hit3[p]) begin
          rd_data[p] = bus.wd3;
        end
        if (hit3[p] || hit4[p]) begin
          rd_busy[p] = 1'b0;
        end
      end
      if (ZERO_REG != 0 && rd_addr[p] == '0) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign bus.rd1      = rd_data[0];
  assign bus.rd2      = rd_data[1];
  assign bus.busy1    = rd_busy[0];
  assign bus.busy2    = rd_busy[1];
  assign bus.busy_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Directed bench: a default (zero reg, bypass) instance and a plain instance
// (no zero reg, no bypass) see the same stimulus and are checked side by side.
module tb_regfile_2w2r_sb;
  logic        clock;
  logic        reset;
  logic [4:0]  a1, a2, a3, a4, rsv_addr;
  logic [31:0] wd3, wd4;
  logic        we3, we4, rsv_en;

  int tests_run;
  int tests_failed;

  regfile_2w2r_sb_if #(.WIDTH(32), .AW(5)) bus0 ();
  regfile_2w2r_sb_if #(.WIDTH(32), .AW(5)) bus1 ();

  assign bus0.a1_in = a1;       assign bus1.a1_in = a1;
  assign bus0.a2_in = a2;       assign bus1.a2_in = a2;
  assign bus0.a3_in = a3;       assign bus1.a3_in = a3;
  assign bus0.a4_in = a4;       assign bus1.a4_in = a4;
  assign bus0.wd3 = wd3;        assign bus1.wd3 = wd3;
  assign bus0.wd4 = wd4;        assign bus1.wd4 = wd4;
  assign bus0.we3 = we3;        assign bus1.we3 = we3;
  assign bus0.we4 = we4;        assign bus1.we4 = we4;
  assign bus0.rsv_en = rsv_en;  assign bus1.rsv_en = rsv_en;
  assign bus0.rsv_addr = rsv_addr;
  assign bus1.rsv_addr = rsv_addr;

  regfile_2w2r_sb #(.WIDTH(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0)
  );

  regfile_2w2r_sb #(.WIDTH(32), .AW(5), .ZERO_REG(0), .BYPASS(0)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [63:0] got,
                              input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    we3 = 1'b0; we4 = 1'b0; rsv_en = 1'b0;
    a3 = '0; a4 = '0; wd3 = '0; wd4 = '0; rsv_addr = '0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    a1 = '0; a2 = '0;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Every address reads back zero after reset on both ports
    for (int i = 0; i < 32; i++) begin
      a1 = 5'(i);
      a2 = 5'(31 - i);
      #1;
      check_output("reset_rd1_d0", bus0.rd1, 0);
      check_output("reset_rd2_d0", bus0.rd2, 0);
      check_output("reset_busy1_d0", bus0.busy1, 0);
      check_output("reset_busy2_d0", bus0.busy2, 0);
      check_output("reset_rd1_d1", bus1.rd1, 0);
      check_output("reset_rd2_d1", bus1.rd2, 0);
    end
    check_output("reset_cnt_d0", bus0.busy_cnt, 0);
    check_output("reset_cnt_d1", bus1.busy_cnt, 0);
    tick();

    // Same-cycle bypass versus next-cycle visibility
    a1 = 5; a3 = 5; wd3 = 32'hDEADBEEF; we3 = 1'b1;
    #1;
    check_output("bypass_same_d0", bus0.rd1, 32'hDEADBEEF);
    check_output("nobypass_same_d1", bus1.rd1, 0);
    tick();
    idle_inputs();
    #1;
    check_output("bypass_next_d0", bus0.rd1, 32'hDEADBEEF);
    check_output("nobypass_next_d1", bus1.rd1, 32'hDEADBEEF);

    // Colliding writes: port 4 wins, both forwarded and stored
    a1 = 9; a2 = 9;
    a3 = 9; wd3 = 32'h11111111; we3 = 1'b1;
    a4 = 9; wd4 = 32'h22222222; we4 = 1'b1;
    #1;
    check_output("collide_fwd_d0", bus0.rd2, 32'h22222222);
    check_output("collide_fwd_d1", bus1.rd2, 0);
    tick();
    idle_inputs();
    #1;
    check_output("collide_rd1_d0", bus0.rd1, 32'h22222222);
    check_output("collide_rd1_d1", bus1.rd1, 32'h22222222);

    // Register 0: hardwired on dut0, ordinary on dut1 (reserve beats write)
    a1 = 0; a2 = 0;
    a3 = 0; wd3 = 32'hFFFFFFFF; we3 = 1'b1;
    rsv_en = 1'b1; rsv_addr = 0;
    #1;
    check_output("zero_rd_same_d0", bus0.rd1, 0);
    check_output("zero_busy_same_d0", bus0.busy1, 0);
    check_output("zero_busy_same_d1", bus1.busy1, 0);
    tick();
    idle_inputs();
    #1;
    check_output("zero_rd_d0", bus0.rd1, 0);
    check_output("zero_busy_d0", bus0.busy2, 0);
    check_output("zero_cnt_d0", bus0.busy_cnt, 0);
    check_output("r0_rd_d1", bus1.rd1, 32'hFFFFFFFF);
    check_output("r0_busy_d1", bus1.busy2, 1);
    check_output("r0_cnt_d1", bus1.busy_cnt, 1);

    // Asynchronous reset between clock edges clears everything at once
    reset = 1'b1;
    #1;
    check_output("async_cnt_d1", bus1.busy_cnt, 0);
    check_output("async_rd_d1", bus1.rd1, 0);
    check_output("async_busy_d1", bus1.busy1, 0);
    #1 reset = 1'b0;
    tick();

    // Reserve, reserve-with-write, then plain write of address 7
    a1 = 7; a2 = 7;
    rsv_en = 1'b1; rsv_addr = 7;
    #1;
    check_output("rsv_not_yet_d0", bus0.busy1, 0);
    tick();
    idle_inputs();
    #1;
    check_output("rsv_busy_d0", bus0.busy1, 1);
    check_output("rsv_cnt_d0", bus0.busy_cnt, 1);
    check_output("rsv_busy_d1", bus1.busy2, 1);
    check_output("rsv_cnt_d1", bus1.busy_cnt, 1);
    a4 = 7; wd4 = 32'h00000077; we4 = 1'b1;
    rsv_en = 1'b1; rsv_addr = 7;
    #1;
    check_output("wr_rsv_fwd_busy_d0", bus0.busy1, 0);
    check_output("wr_rsv_busy_same_d1", bus1.busy1, 1);
    tick();
    idle_inputs();
    #1;
    check_output("wr_rsv_busy_d0", bus0.busy1, 1);
    check_output("wr_rsv_cnt_d0", bus0.busy_cnt, 1);
    check_output("wr_rsv_busy_d1", bus1.busy1, 1);
    check_output("wr_rsv_cnt_d1", bus1.busy_cnt, 1);
    check_output("wr_rsv_data_d0", bus0.rd2, 32'h00000077);
    a3 = 7; wd3 = 32'h00000078; we3 = 1'b1;
    #1;
    check_output("release_busy_same_d0", bus0.busy1, 0);
    check_output("release_busy_same_d1", bus1.busy1, 1);
    check_output("release_cnt_same_d0", bus0.busy_cnt, 1);
    tick();
    idle_inputs();
    #1;
    check_output("release_cnt_d0", bus0.busy_cnt, 0);
    check_output("release_cnt_d1", bus1.busy_cnt, 0);
    check_output("release_busy_d1", bus1.busy1, 0);
    check_output("release_data_d1", bus1.rd1, 32'h00000078);

    // Fill the scoreboard one reservation per cycle
    for (int i = 1; i < 32; i++) begin
      rsv_en = 1'b1;
      rsv_addr = 5'(i);
      tick();
      check_output("fill_cnt_d0", bus0.busy_cnt, 64'(i));
      check_output("fill_cnt_d1", bus1.busy_cnt, 64'(i));
    end
    rsv_addr = 0;
    tick();
    check_output("full_cnt_d0", bus0.busy_cnt, 31);
    check_output("full_cnt_d1", bus1.busy_cnt, 32);
    a1 = 9; a2 = 7;
    #1;
    check_output("full_busy1_d0", bus0.busy1, 1);

    // Reset lands mid-sequence with a reserve and a write still driven
    rsv_addr = 3;
    a3 = 12; wd3 = 32'hCAFEF00D; we3 = 1'b1;
    reset = 1'b1;
    #1;
    check_output("midrst_cnt_d0", bus0.busy_cnt, 0);
    check_output("midrst_cnt_d1", bus1.busy_cnt, 0);
    check_output("midrst_rd1_d0", bus0.rd1, 0);
    check_output("midrst_rd2_d1", bus1.rd2, 0);
    check_output("midrst_busy1_d0", bus0.busy1, 0);
    tick();
    check_output("hold_rst_cnt_d0", bus0.busy_cnt, 0);
    check_output("hold_rst_cnt_d1", bus1.busy_cnt, 0);
    reset = 1'b0;
    idle_inputs();
    a1 = 12; a2 = 3;
    tick();
    check_output("post_rst_rd_d0", bus0.rd1, 0);
    check_output("post_rst_rd_d1", bus1.rd1, 0);
    check_output("post_rst_busy_d0", bus0.busy2, 0);
    check_output("post_rst_busy_d1", bus1.busy2, 0);
    check_output("post_rst_cnt_d1", bus1.busy_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
